// File: rtl/alu_accum_seq.sv
// WIDTH-bit ALU whose B operand is the low half of a 2*WIDTH accumulator.
// Single-cycle ops plus a WIDTH-cycle shift-add multiply behind a valid/ready request port.
module alu_accum_seq #(
  parameter int WIDTH = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [2:0]           func,
  input  logic                 acc_clr,
  output logic                 out_valid,
  output logic [2*WIDTH-1:0]   result,
  output logic                 zero,
  output logic                 carry,
  output logic                 state_dbg
);

  // Handshake: a request is accepted on a rising edge where in_valid and in_ready
  // are both high; in_ready never depends on in_valid, and requests seen while
  // in_ready is low are dropped rather than queued.

  localparam int RW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] W_LIM   = WIDTH[WIDTH-1:0];
  localparam logic [CW-1:0]    CNT_END = CW'(WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, MUL = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   result_q, result_d;
  logic            zero_q, zero_d;
  logic            carry_q, carry_d;
  logic            out_valid_q, out_valid_d;
  logic [RW-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [RW-1:0]   prod_q, prod_d;
  logic [CW-1:0]   count_q, count_d;

  logic [WIDTH-1:0] op_b;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] narrow;
  logic [RW-1:0]    alu_res;
  logic             alu_carry;
  logic [RW-1:0]    prod_step;
  logic             accept;

  assign op_b      = result_q[WIDTH-1:0];
  assign in_ready  = reset_n & (state_q == IDLE) & ~acc_clr;
  assign accept    = in_valid & in_ready;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign state_dbg = state_q;

  always_comb begin
    sum_ext   = '0;
    narrow    = '0;
    alu_res   = '0;
    alu_carry = 1'b0;
    case (func)
      3'b000: begin
        sum_ext   = {1'b0, a} + {{WIDTH{1'b0}}, 1'b1};
        alu_res   = {{WIDTH{1'b0}}, sum_ext[WIDTH-1:0]};
        alu_carry = sum_ext[WIDTH];
      end
      3'b001: begin
        sum_ext   = {1'b0, a} + {1'b0, op_b};
        alu_res   = {{WIDTH{1'b0}}, sum_ext[WIDTH-1:0]};
        alu_carry = sum_ext[WIDTH];
      end
      3'b010: begin
        sum_ext   = {1'b0, a} - {1'b0, op_b};
        alu_res   = {{WIDTH{1'b0}}, sum_ext[WIDTH-1:0]};
        alu_carry = (a < op_b);
      end
      3'b011: alu_res = {a ^ op_b, a | op_b};
      3'b100: alu_res = {{(RW-1){1'b0}}, |{a, op_b}};
      3'b101: begin
        // shift distances of WIDTH or more flush the operand entirely
        narrow  = (a >= W_LIM) ? '0 : (op_b << a);
        alu_res = {{WIDTH{1'b0}}, narrow};
      end
      3'b110: begin
        narrow  = (a >= W_LIM) ? '0 : (op_b >> a);
        alu_res = {{WIDTH{1'b0}}, narrow};
      end
      default: alu_res = '0;
    endcase
  end

  assign prod_step = prod_q + (mplier_q[0] ? (mcand_q << count_q) : '0);

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    out_valid_d = 1'b0;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    prod_d      = prod_q;
    count_d     = count_q;
    case (state_q)
      IDLE: begin
        if (acc_clr) begin
          result_d = '0;
          zero_d   = 1'b1;
          carry_d  = 1'b0;
        end else if (accept) begin
          if (func == 3'b111) begin
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = op_b;
            prod_d   = '0;
            count_d  = '0;
            state_d  = MUL;
          end else begin
            result_d    = alu_res;
            zero_d      = (alu_res == '0);
            carry_d     = alu_carry;
            out_valid_d = 1'b1;
          end
        end
      end
      MUL: begin
        if (acc_clr) begin
          result_d = '0;
          zero_d   = 1'b1;
          carry_d  = 1'b0;
          state_d  = IDLE;
        end else begin
          prod_d   = prod_step;
          mplier_d = mplier_q >> 1;
          count_d  = count_q + 1'b1;
          if (count_q == CNT_END) begin
            result_d    = prod_step;
            zero_d      = (prod_step == '0);
            carry_d     = 1'b0;
            out_valid_d = 1'b1;
            state_d     = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      result_q    <= '0;
      zero_q      <= 1'b1;
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      prod_q      <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      out_valid_q <= out_valid_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      prod_q      <= prod_d;
      count_q     <= count_d;
    end
  end

endmodule

// File: tb/tb_alu_accum_seq.sv
// Directed bench for alu_accum_seq (WIDTH=4): driver pushes expected {carry,zero,result}
// into a queue, a negedge monitor pops and compares whenever out_valid is seen.
module tb_alu_accum_seq;

  localparam int W  = 4;
  localparam int RW = 2 * W;

  logic          clock;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [2:0]    func;
  logic          acc_clr;
  logic          out_valid;
  logic [RW-1:0] result;
  logic          zero;
  logic          carry;
  logic          state_dbg;

  int checks;
  int failures;
  logic [RW+1:0] exp_q[$];

  alu_accum_seq #(.WIDTH(W)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .func      (func),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .result    (result),
    .zero      (zero),
    .carry     (carry),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clock) begin
    if (reset_n === 1'b1 && out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else begin
        logic [RW+1:0] e;
        e = exp_q.pop_front();
        check("result_flags", 32'({carry, zero, result}), 32'(e));
      end
    end
  end

  // driver: waits (bounded) for in_ready, presents one request for one edge
  task automatic issue(input logic [W-1:0] av, input logic [2:0] fv,
                       input logic [RW-1:0] er, input logic ec, input bit push);
    int n;
    n = 0;
    @(negedge clock);
    #1;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clock);
      #1;
      n++;
    end
    if (in_ready !== 1'b1) begin
      check("issue_ready_timeout", 32'(in_ready), 32'd1);
    end else begin
      in_valid = 1'b1;
      a        = av;
      func     = fv;
      if (push) exp_q.push_back({ec, (er == '0), er});
      @(posedge clock);
      #1;
      in_valid = 1'b0;
    end
  endtask

  // multiply with in-flight input scrambling; returns number of cycles in_ready stayed low
  task automatic mul(input logic [W-1:0] av, input logic [RW-1:0] er, output int busy);
    busy = 0;
    issue(av, 3'b111, er, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      a    = W'($urandom_range(0, 15));
      func = 3'($urandom_range(0, 7));
      #1;
      if (in_ready === 1'b1) break;
      busy++;
    end
  endtask

  initial begin
    int busy;
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    func     = '0;
    acc_clr  = 1'b0;

    repeat (3) @(negedge clock);
    check("ready_in_reset", 32'(in_ready), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);
    check("rst_result", 32'(result), 32'h00);
    check("rst_zero", 32'(zero), 32'd1);
    check("rst_carry", 32'(carry), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    issue(4'd5, 3'b001, 8'h05, 1'b0, 1'b1);
    check("pulse_high", 32'(out_valid), 32'd1);
    @(posedge clock);
    #1;
    check("pulse_low", 32'(out_valid), 32'd0);

    mul(4'd3, 8'h0F, busy);
    check("mul_busy_cycles", 32'(busy), 32'd4);

    issue(4'd1, 3'b001, 8'h00, 1'b1, 1'b1);
    issue(4'd2, 3'b010, 8'h02, 1'b0, 1'b1);
    issue(4'd2, 3'b000, 8'h03, 1'b0, 1'b1);
    issue(4'd1, 3'b101, 8'h06, 1'b0, 1'b1);
    issue(4'd9, 3'b110, 8'h00, 1'b0, 1'b1);
    issue(4'd1, 3'b000, 8'h02, 1'b0, 1'b1);
    issue(4'd4, 3'b101, 8'h00, 1'b0, 1'b1);
    issue(4'hA, 3'b001, 8'h0A, 1'b0, 1'b1);
    issue(4'h6, 3'b011, 8'hCE, 1'b0, 1'b1);
    issue(4'h0, 3'b100, 8'h01, 1'b0, 1'b1);
    issue(4'd3, 3'b010, 8'h02, 1'b0, 1'b1);
    issue(4'd1, 3'b010, 8'h0F, 1'b1, 1'b1);
    issue(4'hF, 3'b000, 8'h00, 1'b1, 1'b1);
    issue(4'd9, 3'b001, 8'h09, 1'b0, 1'b1);
    issue(4'd1, 3'b110, 8'h04, 1'b0, 1'b1);
    issue(4'd3, 3'b101, 8'h00, 1'b0, 1'b1);
    issue(4'hE, 3'b000, 8'h0F, 1'b0, 1'b1);
    mul(4'hF, 8'hE1, busy);
    check("mul_max_busy", 32'(busy), 32'd4);
    issue(4'd1, 3'b011, 8'h01, 1'b0, 1'b1);

    // clear while idle with a request present
    @(negedge clock);
    in_valid = 1'b1;
    a        = 4'd3;
    func     = 3'b001;
    acc_clr  = 1'b1;
    #1;
    check("clr_idle_ready", 32'(in_ready), 32'd0);
    @(posedge clock);
    #1;
    check("clr_idle_result", 32'({carry, zero, result}), 32'({1'b0, 1'b1, 8'h00}));
    check("clr_idle_no_valid", 32'(out_valid), 32'd0);
    @(negedge clock);
    in_valid = 1'b0;
    acc_clr  = 1'b0;

    // abort a multiply with acc_clr in its second cycle
    issue(4'd5, 3'b001, 8'h05, 1'b0, 1'b1);
    issue(4'd7, 3'b111, 8'h00, 1'b0, 1'b0);
    @(negedge clock);
    @(negedge clock);
    acc_clr = 1'b1;
    #1;
    check("abort_busy_ready", 32'(in_ready), 32'd0);
    @(posedge clock);
    #1;
    check("abort_result", 32'({carry, zero, result}), 32'({1'b0, 1'b1, 8'h00}));
    check("abort_no_valid", 32'(out_valid), 32'd0);
    check("abort_state", 32'(state_dbg), 32'd0);
    @(negedge clock);
    acc_clr = 1'b0;
    #1;
    check("abort_ready_after", 32'(in_ready), 32'd1);
    repeat (6) @(negedge clock);

    // reset in the middle of a multiply
    issue(4'd5, 3'b001, 8'h05, 1'b0, 1'b1);
    issue(4'd3, 3'b111, 8'h00, 1'b0, 1'b0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("rst_mid_result", 32'({carry, zero, result}), 32'({1'b0, 1'b1, 8'h00}));
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    check("rst_mid_ready", 32'(in_ready), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("rst_mid_ready_after", 32'(in_ready), 32'd1);
    repeat (8) @(negedge clock);
    check("rst_mid_hold", 32'(result), 32'h00);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
